// File: rtl/ml_scaling_pkg.sv
// rtl/ml_scaling_pkg.sv - shared types and constants for the ml fixed-point scaling stages
//
// Contents:
//   state_t  : IDLE / CALC / DONE sequencing of the inverse scaling block
//   div_w    : dividend width for a given data width (room for a 31-bit left shift)
//   sat_max  : largest signed value of a given width
//   sat_min  : most negative signed value of a given width
package ml_scaling_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int div_w(input int data_width);
    return data_width + 31;
  endfunction

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/inverse_scaling_if.sv
// rtl/inverse_scaling_if.sv - request/result handshake bundle for inverse_scaling
//
// Ports (master = producer/consumer side, slave = inverse_scaling):
//   in_valid/in_ready                       request handshake
//   in_data, scale_factor, shift_amount     request operands
//   out_valid/out_ready                     result handshake
//   out_data, out_sat, out_div0             result and status flags
interface inverse_scaling_if
  import ml_scaling_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16
);

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [SCALE_WIDTH-1:0] scale_factor;
  logic [4:0]             shift_amount;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_sat;
  logic                   out_div0;

  modport master (
    output in_valid, in_data, scale_factor, shift_amount, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_div0
  );

  modport slave (
    input  in_valid, in_data, scale_factor, shift_amount, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_div0
  );

endinterface

// File: rtl/udiv_restoring_step.sv
// rtl/udiv_restoring_step.sv - one combinational step of an unsigned restoring divide
//
// Ports:
//   rem_in   partial remainder, always < divisor
//   divisor  unsigned divisor
//   next_bit next dividend bit, MSB first
//   rem_out  updated partial remainder
//   q_bit    quotient bit produced by this step
module udiv_restoring_step
  import ml_scaling_pkg::*;
#(
  parameter int SCALE_WIDTH = 16
) (
  input  logic [SCALE_WIDTH-1:0] rem_in,
  input  logic [SCALE_WIDTH-1:0] divisor,
  input  logic                   next_bit,
  output logic [SCALE_WIDTH-1:0] rem_out,
  output logic                   q_bit
);

  // One extra bit so the shifted remainder never overflows before the compare.
  logic [SCALE_WIDTH:0] trial;

  always_comb begin
    trial   = {rem_in, next_bit};
    q_bit   = (trial >= {1'b0, divisor});
    // After a successful subtract the result is < divisor, so it fits back in SCALE_WIDTH.
    rem_out = q_bit ? SCALE_WIDTH'(trial - {1'b0, divisor}) : trial[SCALE_WIDTH-1:0];
  end

endmodule

// File: rtl/inverse_scaling.sv
// rtl/inverse_scaling.sv - dequantization: (in_data << shift_amount) / scale_factor with saturation
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    inverse_scaling_if.slave: request (in_*, scale_factor, shift_amount)
//          and registered result (out_data, out_sat, out_div0) with valid/ready
module inverse_scaling
  import ml_scaling_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  inverse_scaling_if.slave  bus
);

  localparam int DIV_W = div_w(DATA_WIDTH);
  localparam int CNT_W = $clog2(DIV_W);

  localparam logic [DATA_WIDTH-1:0] OUT_MAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = DATA_WIDTH'(sat_min(DATA_WIDTH));
  // Largest magnitudes representable with a positive / negative sign.
  localparam logic [DIV_W-1:0]      POS_LIM = DIV_W'(sat_max(DATA_WIDTH));
  localparam logic [DIV_W-1:0]      NEG_LIM = POS_LIM + DIV_W'(1);

  state_t state, state_nxt;

  logic [DIV_W-1:0]       dividend;
  logic [SCALE_WIDTH-1:0] divisor;
  logic [SCALE_WIDTH-1:0] rem;
  logic [DIV_W-1:0]       quot;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   res_neg;
  logic                   in_neg;
  logic                   in_zero;
  logic                   div0;

  logic                   out_valid_r;
  logic [DATA_WIDTH-1:0]  out_data_r;
  logic                   out_sat_r;
  logic                   out_div0_r;

  logic                   in_ready_c;
  logic                   accept;

  // Operand magnitudes: widen by one bit first so the most negative value negates cleanly.
  logic signed [DATA_WIDTH:0]  in_ext;
  logic        [DATA_WIDTH:0]  in_mag;
  logic signed [SCALE_WIDTH:0] scale_ext;
  logic [SCALE_WIDTH-1:0]      scale_mag;
  logic [DIV_W-1:0]            dividend_in;

  logic [SCALE_WIDTH-1:0] rem_nxt;
  logic                   q_bit;

  logic [DATA_WIDTH-1:0]  res_data;
  logic                   res_sat;

  always_comb begin
    in_ext      = {bus.in_data[DATA_WIDTH-1], bus.in_data};
    in_mag      = in_ext[DATA_WIDTH] ? -in_ext : in_ext;
    scale_ext   = {bus.scale_factor[SCALE_WIDTH-1], bus.scale_factor};
    scale_mag   = SCALE_WIDTH'(scale_ext[SCALE_WIDTH] ? -scale_ext : scale_ext);
    dividend_in = DIV_W'(in_mag) << bus.shift_amount;
  end

  udiv_restoring_step #(
    .SCALE_WIDTH (SCALE_WIDTH)
  ) u_step (
    .rem_in   (rem),
    .divisor  (divisor),
    .next_bit (dividend[bit_cnt]),
    .rem_out  (rem_nxt),
    .q_bit    (q_bit)
  );

  // Sign and saturation act on the completed quotient during the first DONE cycle,
  // keeping the wide compare/negate off the divider step path.
  always_comb begin
    res_data = '0;
    res_sat  = 1'b0;
    if (div0) begin
      if (!in_zero) begin
        res_data = in_neg ? OUT_MIN : OUT_MAX;
        res_sat  = 1'b1;
      end
    end else if (!res_neg) begin
      if (quot > POS_LIM) begin
        res_data = OUT_MAX;
        res_sat  = 1'b1;
      end else begin
        res_data = quot[DATA_WIDTH-1:0];
      end
    end else begin
      if (quot > NEG_LIM) begin
        res_data = OUT_MIN;
        res_sat  = 1'b1;
      end else begin
        res_data = -quot[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = (bus.scale_factor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (bit_cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_valid_r && bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
      bit_cnt  <= '0;
      res_neg  <= 1'b0;
      in_neg   <= 1'b0;
      in_zero  <= 1'b0;
      div0     <= 1'b0;
    end else if (accept) begin
      dividend <= dividend_in;
      divisor  <= scale_mag;
      rem      <= '0;
      quot     <= '0;
      bit_cnt  <= CNT_W'(DIV_W - 1);
      res_neg  <= bus.in_data[DATA_WIDTH-1] ^ bus.scale_factor[SCALE_WIDTH-1];
      in_neg   <= bus.in_data[DATA_WIDTH-1];
      in_zero  <= (bus.in_data == '0);
      div0     <= (bus.scale_factor == '0);
    end else if (state == CALC) begin
      rem      <= rem_nxt;
      quot     <= {quot[DIV_W-2:0], q_bit};
      bit_cnt  <= bit_cnt - 1'b1;
    end
  end

  // out_valid rises one cycle after DONE is entered and drops on the result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
      out_div0_r  <= 1'b0;
    end else if (state == DONE) begin
      if (!out_valid_r) begin
        out_valid_r <= 1'b1;
        out_data_r  <= res_data;
        out_sat_r   <= res_sat;
        out_div0_r  <= div0;
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_div0  = out_div0_r;

endmodule

// File: tb/tb_inverse_scaling.sv
// tb/tb_inverse_scaling.sv - scoreboard bench for inverse_scaling
module tb_inverse_scaling;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    logic        div0;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;

  inverse_scaling_if #(.DATA_WIDTH(32), .SCALE_WIDTH(16)) bus ();

  inverse_scaling #(
    .DATA_WIDTH  (32),
    .SCALE_WIDTH (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   acc_cyc      = 0;
  int   hs_cyc       = 0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int in_v, input int sc, input int sh);
    exp_t   e;
    longint num;
    longint q;
    e.div0 = (sc == 0);
    e.lat  = (sc == 0) ? 1 : 64;
    e.sat  = 1'b0;
    e.data = 32'h0;
    if (sc == 0) begin
      if (in_v > 0) begin
        e.data = 32'h7FFF_FFFF;
        e.sat  = 1'b1;
      end else if (in_v < 0) begin
        e.data = 32'h8000_0000;
        e.sat  = 1'b1;
      end
    end else begin
      num = longint'(in_v) * (64'sd1 <<< sh);
      q   = num / longint'(sc);
      if (q > 64'sd2147483647) begin
        e.data = 32'h7FFF_FFFF;
        e.sat  = 1'b1;
      end else if (q < -64'sd2147483648) begin
        e.data = 32'h8000_0000;
        e.sat  = 1'b1;
      end else begin
        e.data = q[31:0];
      end
    end
    return e;
  endfunction

  task automatic send(input int in_v, input int sc, input int sh, input bit push);
    int n = 0;
    @(negedge clk);
    bus.in_data      = in_v;
    bus.scale_factor = sc[15:0];
    bus.shift_amount = sh[4:0];
    bus.in_valid     = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (push) sb.push_back(model(in_v, sc, sh));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      check("valid_timeout", 64'd0, 64'd1);
    end else if (sb.size() > 0) begin
      check("latency", cyc - acc_cyc, sb[0].lat);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check("out_data", bus.out_data, e.data);
    check("out_sat", bus.out_sat, e.sat);
    check("out_div0", bus.out_div0, e.div0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 1'b0);
  endtask

  task automatic run_one(input int in_v, input int sc, input int sh);
    send(in_v, sc, sh, 1'b1);
    wait_valid();
    pop_compare();
  endtask

  initial begin
    logic [31:0] snap;
    logic [15:0] s16;
    int          in_v;
    int          sc;
    int          sh;

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.in_data      = '0;
    bus.scale_factor = '0;
    bus.shift_amount = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 32'h0);
    check("rst_out_sat", bus.out_sat, 1'b0);
    check("rst_out_div0", bus.out_div0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one(50, 256, 8);
    run_one(-7, 2, 0);
    run_one(7, -2, 0);
    run_one(32'h4000_0000, 1, 4);
    run_one(-32'sh4000_0000, 1, 1);
    run_one(-5, 0, 3);
    run_one(0, 0, 0);
    run_one(5, 0, 0);
    run_one(-32'sh8000_0000, -1, 0);
    run_one(-32'sh8000_0000, 32767, 31);

    // Backpressure with a second request waiting behind the stalled result.
    send(1234, -3, 2, 1'b1);
    wait_valid();
    snap             = bus.out_data;
    bus.in_data      = 99;
    bus.scale_factor = 16'd9;
    bus.shift_amount = 5'd0;
    bus.in_valid     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable", bus.out_data, snap);
      check("bp_valid_held", bus.out_valid, 1'b1);
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    pop_compare();
    check("bp_in_ready_after", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    check("bp_accept_cycle", acc_cyc, hs_cyc + 1);
    sb.push_back(model(99, 9, 0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid();
    pop_compare();

    // Asynchronous reset in the middle of a division.
    send(1000, 3, 5, 1'b0);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_out_data", bus.out_data, 32'h0);
    check("mid_rst_out_sat", bus.out_sat, 1'b0);
    check("mid_rst_out_div0", bus.out_div0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(100, 4, 0);

    for (int i = 0; i < 10; i++) begin
      in_v = int'($urandom);
      s16  = 16'($urandom);
      sc   = int'($signed(s16));
      if (i % 2 == 1) begin
        sc = int'($urandom_range(1, 9));
        if (i % 4 == 1) sc = -sc;
      end
      sh = int'($urandom_range(0, 31));
      run_one(in_v, sc, sh);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
